// File: rtl/memory_access_arbiter_if.sv
// rtl/memory_access_arbiter_if.sv - requester and shared-memory signals of memory_access_arbiter
interface memory_access_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int data_width = 8,
  parameter int addr_width = 8
);
  logic [NUM_REQ-1:0]            access_request;
  logic [NUM_REQ-1:0]            access_granted;
  logic [NUM_REQ*addr_width-1:0] req_addr;
  logic [NUM_REQ*data_width-1:0] req_data;
  logic [NUM_REQ-1:0]            req_wren;
  logic [data_width-1:0]         req_q;
  logic [addr_width-1:0]         mem_addr;
  logic [data_width-1:0]         mem_data;
  logic                          mem_wren;
  logic [data_width-1:0]         mem_q;

  // master: the requesters plus memory; slave: the arbiter
  modport master (
    output access_request, req_addr, req_data, req_wren, mem_q,
    input  access_granted, req_q, mem_addr, mem_data, mem_wren
  );

  modport slave (
    input  access_request, req_addr, req_data, req_wren, mem_q,
    output access_granted, req_q, mem_addr, mem_data, mem_wren
  );
endinterface

// File: rtl/memory_access_arbiter.sv
// rtl/memory_access_arbiter.sv - IDLE/GRANTED shared-memory arbiter; fixed priority by default,
// round robin when ARBITER_ROUND_ROBIN_EN is defined.
module memory_access_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int data_width = 8,
  parameter int addr_width = 8
) (
  input logic                    clk,
  input logic                    reset,
  memory_access_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE = 1'b0, GRANTED = 1'b1} state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] owner, owner_next;
  logic [IDX_W-1:0] pick;
  logic             pick_valid;

`ifdef ARBITER_ROUND_ROBIN_EN
  logic [IDX_W-1:0] last_owner;

  // Walk from farthest to nearest so the requester right after last_owner wins.
  always_comb begin
    int               j;
    logic [IDX_W-1:0] idx;
    j          = 0;
    idx        = '0;
    pick       = '0;
    pick_valid = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = int'(last_owner) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      idx = IDX_W'(j);
      if (bus.access_request[idx]) begin
        pick       = idx;
        pick_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_owner <= IDX_W'(NUM_REQ - 1);
    else if (state == IDLE && pick_valid)
      last_owner <= pick;
  end
`else
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.access_request[i]) begin
        pick       = IDX_W'(i);
        pick_valid = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      owner <= '0;
    end else begin
      state <= state_next;
      owner <= owner_next;
    end
  end

  // A release always lands in IDLE, so back-to-back grants get a gap cycle.
  always_comb begin
    state_next = state;
    owner_next = owner;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_next = GRANTED;
          owner_next = pick;
        end
      end
      GRANTED: begin
        if (!bus.access_request[owner])
          state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.access_granted = '0;
    bus.mem_addr       = '0;
    bus.mem_data       = '0;
    bus.mem_wren       = 1'b0;
    if (state == GRANTED) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (owner == IDX_W'(i)) begin
          bus.access_granted[i] = 1'b1;
          bus.mem_addr          = bus.req_addr[i*addr_width +: addr_width];
          bus.mem_data          = bus.req_data[i*data_width +: data_width];
          bus.mem_wren          = bus.req_wren[i];
        end
      end
    end
  end

  assign bus.req_q = bus.mem_q;
endmodule

// File: tb/tb_memory_access_arbiter.sv
// tb/tb_memory_access_arbiter.sv - directed and randomized checks of memory_access_arbiter
module tb_memory_access_arbiter;
  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 8;
`ifdef ARBITER_ROUND_ROBIN_EN
  localparam int RR = 1;
`else
  localparam int RR = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  memory_access_arbiter_if #(.NUM_REQ(N), .data_width(DW), .addr_width(AW)) bus ();
  memory_access_arbiter #(.NUM_REQ(N), .data_width(DW), .addr_width(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int m_owner = -1;
  int m_last  = N - 1;
  int held[N];
  int seq[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: who gets the memory when the arbiter is free.
  function automatic int pick_owner(input logic [N-1:0] req);
    int p = -1;
    if (RR != 0) begin
      for (int k = 1; k <= N; k++)
        if (p < 0 && req[(m_last + k) % N]) p = (m_last + k) % N;
    end else begin
      for (int i = 0; i < N; i++)
        if (p < 0 && req[i]) p = i;
    end
    return p;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
  endtask

  task automatic model_edge();
    int p;
    if (reset) begin
      model_reset();
    end else if (m_owner < 0) begin
      p = pick_owner(bus.access_request);
      if (p >= 0) begin
        m_owner = p;
        m_last  = p;
      end
    end else if (!bus.access_request[m_owner]) begin
      m_owner = -1;
    end
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0]  g = '0;
    logic [AW-1:0] a = '0;
    logic [DW-1:0] d = '0;
    logic          w = 1'b0;
    if (m_owner >= 0) begin
      g[m_owner] = 1'b1;
      a = bus.req_addr[m_owner*AW +: AW];
      d = bus.req_data[m_owner*DW +: DW];
      w = bus.req_wren[m_owner];
    end
    check({tag, "_grant"}, 32'(bus.access_granted), 32'(g));
    check({tag, "_addr"},  32'(bus.mem_addr),       32'(a));
    check({tag, "_data"},  32'(bus.mem_data),       32'(d));
    check({tag, "_wren"},  32'(bus.mem_wren),       32'(w));
    check({tag, "_q"},     32'(bus.req_q),          32'(bus.mem_q));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic rand_bus();
    bus.req_addr = (N*AW)'($urandom);
    bus.req_data = (N*DW)'($urandom);
    bus.req_wren = N'($urandom);
    bus.mem_q    = DW'($urandom);
  endtask

  function automatic int granted_index();
    int idx = -1;
    for (int i = 0; i < N; i++)
      if (bus.access_granted[i]) idx = i;
    return idx;
  endfunction

  initial begin
    logic [AW-1:0] a1;
    int prev;
    int obs;
    reset = 1'b1;
    bus.access_request = '0;
    rand_bus();
    model_reset();
    tick("rst");
    tick("rst");
    check("rst_grant_c", 32'(bus.access_granted), 32'h0);
    check("rst_wren_c",  32'(bus.mem_wren),       32'h0);
    check("rst_addr_c",  32'(bus.mem_addr),       32'h0);

    // Release reset with a request already waiting: first arbitration at the next edge.
    reset = 1'b0;
    bus.access_request = 3'b010;
    a1 = bus.req_addr[AW +: AW];
    tick("r028");
    check("r028_grant_c", 32'(bus.access_granted), 32'h2);
    check("r028_addr_c",  32'(bus.mem_addr),       32'(a1));

    bus.access_request = 3'b111;
    repeat (5) begin
      rand_bus();
      tick("r029_hold");
      check("r029_hold_c", 32'(bus.access_granted), 32'h2);
    end
    bus.access_request = 3'b101;
    tick("r029_rel");
    check("r029_gap_c", 32'(bus.access_granted), 32'h0);
    tick("r029_next");
    check("r029_next_c", 32'(bus.access_granted), (RR != 0) ? 32'h4 : 32'h1);

    bus.access_request = '0;
    tick("idle");
    tick("idle");

    bus.access_request = 3'b001;
    bus.req_wren = 3'b110;
    tick("r030_own");
    check("r030_wren0_c", 32'(bus.mem_wren), 32'h0);
    bus.req_wren = 3'b001;
    #1;
    check("r030_wren1_c", 32'(bus.mem_wren), 32'h1);
    check_all("r030_comb");
    bus.access_request = '0;
    tick("r030_rel");

    // All three keep requesting; each owner releases after two granted cycles.
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    reset = 1'b0;
    bus.access_request = '1;
    for (int i = 0; i < N; i++) held[i] = 0;
    seq.delete();
    prev = -1;
    for (int c = 0; c < 12; c++) begin
      tick("r031");
      obs = granted_index();
      if (obs >= 0 && prev < 0) seq.push_back(obs);
      prev = obs;
      bus.access_request = '1;
      if (m_owner >= 0) begin
        held[m_owner]++;
        if (held[m_owner] >= 2) begin
          bus.access_request[m_owner] = 1'b0;
          held[m_owner] = 0;
        end
      end
    end
    check("r031_count", 32'(seq.size()), 32'd4);
    if (seq.size() == 4) begin
      check("r031_g0", 32'(seq[0]), 32'd0);
      check("r031_g1", 32'(seq[1]), (RR != 0) ? 32'd1 : 32'd0);
      check("r031_g2", 32'(seq[2]), (RR != 0) ? 32'd2 : 32'd0);
      check("r031_g3", 32'(seq[3]), 32'd0);
    end

    bus.access_request = '0;
    tick("idle");
    for (int c = 0; c < 400; c++) begin
      if (m_owner >= 0 && $urandom_range(0, 3) != 0) begin
        bus.access_request = N'($urandom);
        bus.access_request[m_owner] = 1'b1;
      end else begin
        bus.access_request = N'($urandom);
      end
      rand_bus();
      if ($urandom_range(0, 63) == 0) begin
        reset = 1'b1;
        model_reset();
        #1;
        check_all("rnd_async_rst");
      end else begin
        reset = 1'b0;
      end
      tick("rnd");
    end
    reset = 1'b0;

    // Asynchronous reset in the middle of a write grant.
    bus.access_request = '0;
    tick("idle");
    bus.access_request = 3'b100;
    bus.req_wren = 3'b100;
    tick("r032_own");
    check("r032_grant_c", 32'(bus.access_granted), 32'h4);
    check("r032_wren_c",  32'(bus.mem_wren),       32'h1);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check("r032_async_grant", 32'(bus.access_granted), 32'h0);
    check("r032_async_wren",  32'(bus.mem_wren),       32'h0);
    check("r032_async_addr",  32'(bus.mem_addr),       32'h0);
    tick("r032_held");
    reset = 1'b0;

    bus.access_request = '0;
    repeat (10) begin
      rand_bus();
      tick("r033");
      check("r033_grant_c", 32'(bus.access_granted), 32'h0);
      check("r033_wren_c",  32'(bus.mem_wren),       32'h0);
      check("r033_addr_c",  32'(bus.mem_addr),       32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/memory_access_arbiter.md
MEMORY_ACCESS_ARBITER -- requirements
Module: memory_access_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 3, giving the number of requesting FSMs (2..8).
REQ-002 The block SHALL have parameter data_width, default 8, giving the shared memory data width.
REQ-003 The block SHALL have parameter addr_width, default 8, giving the shared memory address width.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port access_request, input, NUM_REQ, one request bit per requester.
REQ-007 The block SHALL have port access_granted, output, NUM_REQ, one-hot-or-zero grant per requester.
REQ-008 The block SHALL have port req_addr, input, NUM_REQ*addr_width; requester i occupies bits [i*addr_width +: addr_width].
REQ-009 The block SHALL have port req_data, input, NUM_REQ*data_width; write data, packed as req_addr.
REQ-010 The block SHALL have port req_wren, input, NUM_REQ; write enable per requester.
REQ-011 The block SHALL have ports mem_addr, output, addr_width; mem_data, output, data_width; mem_wren, output, 1: the shared memory port.
REQ-012 The block SHALL have port mem_q, input, data_width, memory read data, and port req_q, output, data_width, mem_q forwarded unchanged to all requesters.

Function
REQ-013 The block SHALL implement two states: IDLE (no grant) and GRANTED (exactly one owner).
REQ-014 In IDLE, if any access_request bit is high at a clock edge, the block SHALL enter GRANTED with the selected owner; access_granted[owner] SHALL be high from the following cycle.
REQ-015 In IDLE with no request, the block SHALL remain in IDLE.
REQ-016 In GRANTED, the grant SHALL be held while access_request[owner] is high; other requests SHALL NOT pre-empt it.
REQ-017 In GRANTED, when access_request[owner] is low at a clock edge, the block SHALL return to IDLE, dropping the grant at that edge; at least one IDLE cycle SHALL separate consecutive grants.
REQ-018 access_granted SHALL be a registered-state decode (no combinational path from access_request).
REQ-019 In GRANTED, mem_addr, mem_data and mem_wren SHALL combinationally follow req_addr, req_data and req_wren of the owner.
REQ-020 In IDLE, mem_addr and mem_data SHALL be 0 and mem_wren SHALL be 0; req_wren of non-owners SHALL never reach mem_wren.
REQ-021 Owner index SHALL be held in a register of ceil(log2(NUM_REQ)) bits; the round-robin pointer SHALL wrap from NUM_REQ-1 to 0.
REQ-022 Simultaneous release by owner and new requests SHALL still pass through IDLE before the next grant.

Reset
REQ-023 While reset is high, state SHALL be IDLE, access_granted SHALL be 0, mem_wren SHALL be 0, mem_addr and mem_data SHALL be 0, and the last-owner pointer SHALL be NUM_REQ-1.
REQ-024 Reset asserted mid-grant SHALL drop all grants and mem_wren immediately, without waiting for clk.
REQ-025 After reset deasserts, the first arbitration SHALL occur at the next rising clk edge.

Configuration
REQ-026 With macro ARBITER_ROUND_ROBIN_EN defined, selection SHALL search from (last owner + 1) mod NUM_REQ upward, wrapping, and the last-owner pointer SHALL update on each grant.
REQ-027 Without ARBITER_ROUND_ROBIN_EN, selection SHALL be fixed priority, lowest index wins, and the last-owner pointer SHALL be absent or unused.

Verification
REQ-028 Reset, then access_request=3'b010 -> access_granted=3'b010 one cycle later; mem_addr follows req_addr[1].
REQ-029 Requester 1 owns; access_request=3'b111 for 5 cycles -> grant stays 3'b010; requester 1 drops -> one cycle grant 3'b000, then 3'b100 (round robin) or 3'b001 (fixed priority).
REQ-030 Requester 0 owns with req_wren=3'b110 -> mem_wren=0; req_wren=3'b001 -> mem_wren=1.
REQ-031 Round robin: all three request continuously, each releasing after 2 granted cycles -> grant order 0,1,2,0 with one idle cycle between each.
REQ-032 Reset asserted mid-cycle while requester 2 owns with mem_wren=1 -> access_granted=0 and mem_wren=0 before the next clk edge.
REQ-033 No requests for 10 cycles -> access_granted=0, mem_wren=0, mem_addr=0 throughout.
